i2s_master_tx: RTL and testbench

// - I2S master transmitter: accepts parallel 24-bit left/right PCM strobes, serialises them onto a

---
 rtl/i2s_master_tx_pkg.sv | 18 +
 rtl/i2s_master_tx_bclk_gen.sv | 82 ++++++++
 rtl/i2s_master_tx.sv | 114 +++++++++++
 tb/tb_i2s_master_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_master_tx_pkg.sv
// Shared audio constants and the bit-clock generator state type for the I2S transmitter.
package i2s_master_tx_pkg;

    localparam int DATA_W    = 24;  // PCM sample width, MSB first
    localparam int SLOT_W    = 32;  // bclk periods per channel slot
    localparam int BCLK_HALF = 4;   // clk cycles per bclk half-period

    // Slot bit 0 carries the one-bit I2S delay; the sample MSB sits at slot bit 1.
    localparam int SLOT_BIT_DELAY = 0;
    localparam int SLOT_BIT_FIRST = SLOT_BIT_DELAY + 1;

    // Generator state: no frame loaded since run rose / frames streaming.
    typedef enum logic {
        GEN_IDLE   = 1'b0,
        GEN_ACTIVE = 1'b1
    } gen_state_e;

endpackage

// File: rtl/i2s_master_tx_bclk_gen.sv
// Bit-clock divider, falling-edge event strobe, frame bit counter and lrclk.
//
// state      | meaning
// GEN_IDLE   | run low, or running but the first falling edge has not occurred yet
// GEN_ACTIVE | frames streaming; bit counter wraps every 2*SLOT_W falling edges
module i2s_master_tx_bclk_gen
    import i2s_master_tx_pkg::*;
#(
    parameter int BCLK_HALF = i2s_master_tx_pkg::BCLK_HALF,
    parameter int SLOT_W    = i2s_master_tx_pkg::SLOT_W,
    localparam int DIV_W    = $clog2(BCLK_HALF),
    localparam int CNT_W    = $clog2(2 * SLOT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             o_bclk,
    output logic             o_lrclk,
    output logic             o_fall,
    output logic             o_frame_load,
    output logic [CNT_W-1:0] o_bit_nxt
);

    gen_state_e       r_state;
    gen_state_e       w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_bit;
    logic             r_bclk;
    logic             r_lrclk;
    logic             w_wrap;
    logic             w_fall;
    logic             w_first;
    logic             w_bit_last;

    assign w_wrap     = (r_div == DIV_W'(BCLK_HALF - 1));
    assign w_fall     = run & ~reset & w_wrap & r_bclk;
    assign w_first    = (r_state == GEN_IDLE);
    assign w_bit_last = (r_bit == CNT_W'(2 * SLOT_W - 1));

    // State register; run low or reset forces the generator back to idle.
    always_ff @(posedge clk) begin
        if (reset) r_state <= GEN_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state plus the frame-load and next-bit decode that depend on it.
    always_comb begin
        w_state_nxt  = r_state;
        o_frame_load = 1'b0;
        o_bit_nxt    = r_bit + 1'b1;
        if (w_first || w_bit_last) o_bit_nxt = '0;
        if (w_fall && (w_first || w_bit_last)) o_frame_load = 1'b1;
        if (!run)        w_state_nxt = GEN_IDLE;
        else if (w_fall) w_state_nxt = GEN_ACTIVE;
    end

    // Divider toggles bclk at each wrap; bit counter and lrclk move only as bclk falls.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_div   <= '0;
            r_bclk  <= 1'b0;
            r_bit   <= '0;
            r_lrclk <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_fall) begin
                r_bit   <= o_bit_nxt;
                r_lrclk <= (o_bit_nxt >= CNT_W'(SLOT_W));
            end
        end
    end

    assign o_bclk  = r_bclk;
    assign o_lrclk = r_lrclk;
    assign o_fall  = w_fall;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: stereo staging buffer, status flags and serial data mux.
module i2s_master_tx
    import i2s_master_tx_pkg::*;
#(
    parameter int BCLK_HALF = i2s_master_tx_pkg::BCLK_HALF,
    parameter int DATA_W    = i2s_master_tx_pkg::DATA_W,
    parameter int SLOT_W    = i2s_master_tx_pkg::SLOT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              l_data_en,
    input  logic              r_data_en,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    input  logic              status_clr,
    output logic              bclk,
    output logic              lrclk,
    output logic              s_data,
    output logic              sample_req,
    output logic              underrun,
    output logic              overrun
);

    localparam int CNT_W = $clog2(2 * SLOT_W);
    localparam int IDX_W = $clog2(DATA_W);

    logic                w_fall;
    logic                w_load;
    logic [CNT_W-1:0]    w_bit_nxt;
    logic [DATA_W-1:0]   r_l_stage;
    logic [DATA_W-1:0]   r_r_stage;
    logic                r_l_pend;
    logic                r_r_pend;
    logic [2*DATA_W-1:0] r_frame;
    logic                r_sdata;
    logic                r_sample_req;
    logic                r_underrun;
    logic                r_overrun;
    logic                w_set_under;
    logic                w_set_over;
    logic [DATA_W-1:0]   w_word;
    logic                w_bit;
    int                  w_k;

    i2s_master_tx_bclk_gen #(
        .BCLK_HALF (BCLK_HALF),
        .SLOT_W    (SLOT_W)
    ) u_bclk_gen (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .o_bclk       (bclk),
        .o_lrclk      (lrclk),
        .o_fall       (w_fall),
        .o_frame_load (w_load),
        .o_bit_nxt    (w_bit_nxt)
    );

    // A missed pair is flagged at load; an overwrite counts only if the old value was not consumed this clk.
    assign w_set_under = w_load & ~(r_l_pend & r_r_pend);
    assign w_set_over  = ~w_load & ((l_data_en & r_l_pend) | (r_data_en & r_r_pend));

    // Pick the slot bit that goes out at the coming falling edge.
    always_comb begin
        w_k    = int'(w_bit_nxt) % SLOT_W;
        w_word = (int'(w_bit_nxt) >= SLOT_W) ? r_frame[DATA_W-1:0] : r_frame[2*DATA_W-1:DATA_W];
        w_bit  = 1'b0;
        if (w_k >= SLOT_BIT_FIRST && w_k <= DATA_W) w_bit = w_word[IDX_W'(DATA_W - w_k)];
    end

    // Staging buffer, frame latch and sticky status; frame load reads the pre-strobe staged values.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_l_stage    <= '0;
            r_r_stage    <= '0;
            r_l_pend     <= 1'b0;
            r_r_pend     <= 1'b0;
            r_frame      <= '0;
            r_sample_req <= 1'b0;
            r_underrun   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sample_req <= w_load;
            if (w_load) begin
                if (r_l_pend && r_r_pend) r_frame <= {r_l_stage, r_r_stage};
                r_l_pend <= 1'b0;
                r_r_pend <= 1'b0;
            end
            if (l_data_en) begin
                r_l_stage <= l_data;
                r_l_pend  <= 1'b1;
            end
            if (r_data_en) begin
                r_r_stage <= r_data;
                r_r_pend  <= 1'b1;
            end
            r_underrun <= w_set_under | (r_underrun & ~status_clr);
            r_overrun  <= w_set_over  | (r_overrun  & ~status_clr);
        end
    end

    // Serial data register changes together with lrclk as bclk falls.
    always_ff @(posedge clk) begin
        if (reset || !run) r_sdata <= 1'b0;
        else if (w_fall)   r_sdata <= w_bit;
    end

    assign s_data     = r_sdata;
    assign sample_req = r_sample_req;
    assign underrun   = r_underrun;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Randomised and directed bench for the I2S master transmitter with a frame-level reference model.
module tb_i2s_master_tx;

    localparam int H  = 4;
    localparam int DW = 24;
    localparam int SW = 32;
    localparam int FRAME_CLKS = 2 * H * 2 * SW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          l_data_en = 1'b0;
    logic          r_data_en = 1'b0;
    logic [DW-1:0] l_data = '0;
    logic [DW-1:0] r_data = '0;
    logic          status_clr = 1'b0;
    logic          bclk, lrclk, s_data, sample_req, underrun, overrun;

    always #5 clk = ~clk;

    i2s_master_tx dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .l_data_en  (l_data_en),
        .r_data_en  (r_data_en),
        .l_data     (l_data),
        .r_data     (r_data),
        .status_clr (status_clr),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .s_data     (s_data),
        .sample_req (sample_req),
        .underrun   (underrun),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: m_n = clk edges seen with run=1 (-1 when idle)
    int              m_n = -1;
    logic            m_lp = 0, m_rp = 0, m_under = 0, m_over = 0, m_load = 0;
    logic [DW-1:0]   m_ls = '0, m_rs = '0;
    logic [2*DW-1:0] m_frame = '0;

    // serial decoder state
    logic            d_prev_bclk = 0, d_prev_lr = 0;
    int              d_pos = -2;
    logic [DW-1:0]   d_word = '0, d_left = '0;
    logic [2*DW-1:0] dec_q[$];
    int              cyc = 0;
    int              last_rise = -1;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic load, su, so, old_lp, old_rp;
        if (reset || !run) begin
            m_n = -1; m_lp = 0; m_rp = 0; m_ls = '0; m_rs = '0;
            m_frame = '0; m_under = 0; m_over = 0; m_load = 0;
        end else begin
            m_n++;
            load = ((m_n + 1) % (2 * H) == 0) && ((((m_n + 1) / (2 * H)) - 1) % (2 * SW) == 0);
            old_lp = m_lp; old_rp = m_rp; su = 0; so = 0;
            if (load) begin
                if (old_lp && old_rp) m_frame = {m_ls, m_rs};
                else su = 1;
                m_lp = 0; m_rp = 0;
            end
            if (l_data_en) begin
                if (old_lp && !load) so = 1;
                m_ls = l_data; m_lp = 1;
            end
            if (r_data_en) begin
                if (old_rp && !load) so = 1;
                m_rs = r_data; m_rp = 1;
            end
            m_under = su | (m_under & ~status_clr);
            m_over  = so | (m_over & ~status_clr);
            m_load  = load;
        end
    endtask

    task automatic compare_all();
        logic          e_bclk, e_lr, e_sd;
        logic [DW-1:0] word;
        int            fl, pos, k;
        e_bclk = 0; e_lr = 0; e_sd = 0;
        if (m_n >= 0) begin
            e_bclk = (((m_n + 1) / H) % 2) == 1;
            fl = (m_n + 1) / (2 * H) - 1;
            if (fl >= 0) begin
                pos  = fl % (2 * SW);
                k    = pos % SW;
                e_lr = pos >= SW;
                word = e_lr ? m_frame[DW-1:0] : m_frame[2*DW-1:DW];
                if (k >= 1 && k <= DW) begin
                    word = word >> (DW - k);
                    e_sd = word[0];
                end
            end
        end
        chk_eq("bclk", 64'(bclk), 64'(e_bclk));
        chk_eq("lrclk", 64'(lrclk), 64'(e_lr));
        chk_eq("s_data", 64'(s_data), 64'(e_sd));
        chk_eq("sample_req", 64'(sample_req), 64'(m_load));
        chk_eq("underrun", 64'(underrun), 64'(m_under));
        chk_eq("overrun", 64'(overrun), 64'(m_over));
    endtask

    task automatic decode();
        if (m_n < 0) begin
            d_pos = -2; d_prev_lr = 0; last_rise = -1;
        end else if (bclk && !d_prev_bclk) begin
            if (last_rise >= 0) chk_eq("bclk_period", 64'(cyc - last_rise), 64'(2 * H));
            last_rise = cyc;
            if (lrclk != d_prev_lr) begin
                if (lrclk) d_left = d_word;
                else       dec_q.push_back({d_left, d_word});
                d_pos = 0;
            end else begin
                d_pos++;
            end
            if (d_pos >= 1 && d_pos <= DW) d_word = {d_word[DW-2:0], s_data};
            d_prev_lr = lrclk;
        end
        d_prev_bclk = bclk;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare_all();
        decode();
        l_data_en = 0; r_data_en = 0; status_clr = 0;
    endtask

    task automatic to_frame_start();
        int i;
        i = 0;
        do begin
            tick();
            i++;
        end while (!m_load && i < FRAME_CLKS + 16);
        if (!m_load) chk_eq("frame_wait_timeout", 64'(m_load), 64'd1);
    endtask

    task automatic stage(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic do_l, input logic do_r);
        l_data = l; r_data = r; l_data_en = do_l; r_data_en = do_r;
    endtask

    task automatic chk_last(input string tag, input int back, input logic [2*DW-1:0] exp);
        if (dec_q.size() > back) chk_eq(tag, 64'(dec_q[dec_q.size()-1-back]), 64'(exp));
        else chk_eq({tag, "_count"}, 64'(dec_q.size()), 64'(back + 1));
    endtask

    initial begin
        int cnt, i, fl;

        // reset, then idle with run low
        reset = 1; run = 0;
        repeat (5) tick();
        reset = 0;
        repeat (500) tick();
        chk_eq("idle_bclk", 64'(bclk), 64'd0);
        chk_eq("idle_sdata", 64'(s_data), 64'd0);
        chk_eq("idle_flags", 64'({underrun, overrun, sample_req}), 64'd0);

        // single frame, then an unfed frame repeats the pair
        run = 1;
        stage(24'hA50F3C, 24'h800001, 1, 1);
        repeat (1 + 3 * FRAME_CLKS) tick();
        chk_last("single_frame", 1, {24'hA50F3C, 24'h800001});
        chk_last("repeat_pair", 0, {24'hA50F3C, 24'h800001});
        chk_eq("underrun_set", 64'(underrun), 64'd1);
        status_clr = 1;
        tick();
        chk_eq("underrun_clr", 64'(underrun), 64'd0);

        // overrun: two left strobes in one frame, the second is sent
        to_frame_start();
        status_clr = 1; tick();
        stage(24'h111111, 24'h0, 1, 0); tick();
        repeat (20) tick();
        stage(24'h222222, 24'h333333, 1, 1); tick();
        chk_eq("overrun_set", 64'(overrun), 64'd1);
        to_frame_start();
        to_frame_start();
        repeat (8) tick();
        chk_last("overrun_data", 0, {24'h222222, 24'h333333});

        // collision: strobes on the exact frame-load clk
        stage(24'h0AAAAA, 24'h0BBBBB, 1, 1); tick();
        status_clr = 1; tick();
        i = 0;
        while (((m_n + 1) % FRAME_CLKS) != 2 * H - 1 && i < FRAME_CLKS + 16) begin
            tick();
            i++;
        end
        stage(24'h0CCCCC, 24'h0DDDDD, 1, 1); tick();
        chk_eq("collide_req", 64'(sample_req), 64'd1);
        chk_eq("collide_overrun", 64'(overrun), 64'd0);
        cnt = 0;
        repeat (2 * FRAME_CLKS) begin
            tick();
            if (sample_req) cnt++;
        end
        chk_eq("req_count", 64'(cnt), 64'd2);
        repeat (8) tick();
        chk_last("collide_old", 1, {24'h0AAAAA, 24'h0BBBBB});
        chk_last("collide_new", 0, {24'h0CCCCC, 24'h0DDDDD});

        // random strobes and status clears
        repeat (12 * FRAME_CLKS) begin
            if ($urandom_range(0, 149) == 0) begin l_data = DW'($urandom); l_data_en = 1; end
            if ($urandom_range(0, 149) == 0) begin r_data = DW'($urandom); r_data_en = 1; end
            if ($urandom_range(0, 499) == 0) status_clr = 1;
            tick();
        end

        // drop run mid right slot, then restart cleanly
        to_frame_start();
        i = 0;
        fl = -1;
        while (fl != 40 && i < FRAME_CLKS + 16) begin
            tick();
            i++;
            fl = (((m_n + 1) % (2 * H)) == 0) ? (((m_n + 1) / (2 * H) - 1) % (2 * SW)) : -1;
        end
        chk_eq("drop_reached_bit40", 64'(fl), 64'd40);
        run = 0;
        tick();
        chk_eq("drop_outputs", 64'({bclk, lrclk, s_data, sample_req}), 64'd0);
        repeat (10) tick();
        run = 1;
        stage(24'h123456, 24'hFEDCBA, 1, 1);
        cnt = dec_q.size();
        repeat (FRAME_CLKS + 20) tick();
        chk_eq("restart_count", 64'(dec_q.size()), 64'(cnt + 1));
        chk_last("restart_frame", 0, {24'h123456, 24'hFEDCBA});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
